// File: rtl/divider_seq_if.sv
`default_nettype none
// =====================================================================
// divider_seq_if : operand/result handshake bundle for divider_seq
// Revision       : 1.0
// =====================================================================
interface divider_seq_if #(
    parameter int DATA_WIDTH = 2048
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     quotient;
    logic [DATA_WIDTH-1:0]     remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// =====================================================================
// divider_seq : unsigned 2W/W restoring divider, one quotient bit per clk
// Revision    : 1.0
// =====================================================================
module divider_seq #(
    parameter int DATA_WIDTH = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    divider_seq_if.slave      bus
);
    localparam int W       = DATA_WIDTH;
    localparam int c_cnt_w = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [W-1:0]         r_quotient;
    logic [W-1:0]         r_remainder;
    logic                 r_div_by_zero;
    logic                 r_overflow;
    logic [W-1:0]         r_rem;
    logic [W-1:0]         r_shift;
    logic [W-1:0]         r_divisor;
    logic [c_cnt_w-1:0]   r_count;

    logic [W-1:0]         w_dvd_hi;
    logic [W:0]           w_tmp;
    logic                 w_ge;
    logic [W-1:0]         w_diff;
    logic [W-1:0]         w_rem_next;
    logic [W-1:0]         w_shift_next;

    assign w_dvd_hi = bus.dividend[2*W-1:W];

    // The difference is always below the divisor when taken, so W bits suffice.
    assign w_tmp        = {r_rem, r_shift[W-1]};
    assign w_ge         = (w_tmp >= {1'b0, r_divisor});
    assign w_diff       = w_tmp[W-1:0] - r_divisor;
    assign w_rem_next   = w_ge ? w_diff : w_tmp[W-1:0];
    assign w_shift_next = {r_shift[W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_rem         <= '0;
            r_shift       <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_state       <= S_DONE;
                            r_out_valid   <= 1'b1;
                            r_div_by_zero <= 1'b1;
                            r_overflow    <= 1'b0;
                            r_quotient    <= '1;
                            r_remainder   <= bus.dividend[W-1:0];
                        end else if (w_dvd_hi >= bus.divisor) begin
                            // Quotient would need more than W bits.
                            r_state       <= S_DONE;
                            r_out_valid   <= 1'b1;
                            r_div_by_zero <= 1'b0;
                            r_overflow    <= 1'b1;
                            r_quotient    <= '1;
                            r_remainder   <= '0;
                        end else begin
                            r_state   <= S_RUN;
                            r_rem     <= w_dvd_hi;
                            r_shift   <= bus.dividend[W-1:0];
                            r_divisor <= bus.divisor;
                            r_count   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_shift <= w_shift_next;
                    r_count <= r_count + c_cnt_one;
                    if (r_count == c_cnt_last) begin
                        r_state       <= S_DONE;
                        r_out_valid   <= 1'b1;
                        r_quotient    <= w_shift_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2048: divisor/quotient/remainder width (W); dividend is 2W, matching the multiplier product width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: operands valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port dividend, input, 2W: unsigned dividend.
REQ-007 SHALL have port divisor, input, W: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1: result valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-010 SHALL have port quotient, output, W: unsigned quotient.
REQ-011 SHALL have port remainder, output, W: unsigned remainder.
REQ-012 SHALL have port div_by_zero, output, 1: divisor was zero.
REQ-013 SHALL have port overflow, output, 1: quotient does not fit in W bits, with divisor nonzero.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready is registered and is 1 only in IDLE.
REQ-015 SHALL accept operands on an edge with in_valid && in_ready; operands are sampled at that edge only and later input changes are ignored.
REQ-016 On accept with divisor==0, SHALL go to DONE at that edge: div_by_zero=1, overflow=0, quotient=all-ones, remainder=dividend[W-1:0].
REQ-017 On accept with divisor!=0 and dividend[2W-1:W] >= divisor, SHALL go to DONE at that edge: overflow=1, div_by_zero=0, quotient=all-ones, remainder=0.
REQ-018 On any other accept, SHALL load partial remainder = dividend[2W-1:W] and shift register = dividend[W-1:0], then go to RUN.
REQ-019 RUN SHALL perform one restoring step per edge, W steps total.
REQ-020 Each RUN step: tmp = {rem, msb of shift reg} (W+1 bits); shift reg shifts left; if tmp >= divisor, rem = tmp - divisor and LSB = 1, else rem = tmp[W-1:0] and LSB = 0.
REQ-021 SHALL complete the W-th RUN step at edge T+W (T = accept edge) and enter DONE with quotient, remainder and both flags=0 registered at that edge.
REQ-022 out_valid SHALL be 1 only in DONE; fast-path latency is 1 edge and normal latency is W edges after the accept edge.
REQ-023 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor whenever both flags are 0.
REQ-024 In DONE, all result outputs SHALL hold stable while out_ready=0, for any number of cycles.
REQ-025 On an edge with out_valid && out_ready, SHALL go to IDLE with in_ready=1 at that edge; a new accept is possible on the next edge (no same-edge accept).
REQ-026 After handoff, quotient, remainder and flags SHALL retain their last values until the next result is registered.
REQ-027 in_valid asserted during RUN or DONE SHALL have no effect.

Reset
REQ-028 While rst_n=0, SHALL hold: state=IDLE, in_ready=0, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, internal registers=0.
REQ-029 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-030 rst_n assertion mid-RUN or in DONE SHALL immediately discard the operation with no out_valid pulse.

Verification
REQ-031 Basic: dividend=100, divisor=7, out_ready=1 -> out_valid exactly 2048 edges after accept; quotient=14, remainder=2, flags=0.
REQ-032 Boundaries:
- divisor=0, dividend=5 -> out_valid 1 edge after accept; div_by_zero=1, quotient=all-ones, remainder=5.
- dividend=2^2048, divisor=1 -> overflow=1, quotient=all-ones, remainder=0, latency 1.
- dividend=(2^2048-1)^2, divisor=2^2048-1 -> quotient=2^2048-1, remainder=0, flags=0.
REQ-033 Back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; handoff on the 6th cycle; a held-high in_valid is accepted on the next edge.
REQ-034 Reset mid-RUN: rst_n low 1000 edges after accept -> all outputs 0 at once; the next operation (100/7) gives the correct result with no stale out_valid.
REQ-035 Random: 10 operations with random 32-bit-word operands, dividend built as a*b + r with r < b -> quotient==a and remainder==r against the bench reference model.
